// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter FSM states, frame geometry and the parity helper.
package ps2_pkg;

   localparam int unsigned DataBits   = 8;
   localparam int unsigned FrameEdges = 11;
   localparam int unsigned KW         = $clog2(FrameEdges + 1);
   localparam int unsigned IdxW       = $clog2(DataBits);

   typedef enum logic [2:0] {
      StIdle,
      StInhibit,
      StRts,
      StShift,
      StRelease,
      StDone
   } ps2_state_e;

   // Odd parity: the parity bit makes the total count of ones odd.
   function automatic logic odd_parity(input logic [DataBits-1:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioner: 2-flop synchronizer, level glitch filter and falling-edge strobe.
module ps2_line_filter #(
   parameter int unsigned FilterLen = 4
) (
   input  logic i_clock,
   input  logic i_rst,
   input  logic i_pin,
   output logic o_level,
   output logic o_fall
);

   localparam int unsigned CntW = $clog2(FilterLen + 1);

   logic [1:0]      r_sync;
   logic            r_level;
   logic            r_level_q;
   logic [CntW-1:0] r_cnt;
   logic            w_level_d;
   logic [CntW-1:0] w_cnt_d;

   // Idle PS/2 lines are pulled high, so reset to 1 to avoid a spurious edge.
   always_ff @(posedge i_clock or posedge i_rst) begin
      if (i_rst) begin
         r_sync    <= 2'b11;
         r_level   <= 1'b1;
         r_level_q <= 1'b1;
         r_cnt     <= '0;
      end else begin
         r_sync    <= {r_sync[0], i_pin};
         r_level   <= w_level_d;
         r_level_q <= r_level;
         r_cnt     <= w_cnt_d;
      end
   end

   always_comb begin
      w_level_d = r_level;
      w_cnt_d   = '0;
      if (r_sync[1] != r_level) begin
         if (r_cnt == CntW'(FilterLen - 1)) begin
            w_level_d = r_sync[1];
         end else begin
            w_cnt_d = r_cnt + 1'b1;
         end
      end
   end

   assign o_level = r_level;
   assign o_fall  = r_level_q & ~r_level;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, device-clocked shift, ACK check
// and timeout recovery on the open-drain clock/data pair.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned InhibitCyc = 3000,
   parameter int unsigned TimeoutCyc = 50000,
   parameter int unsigned FilterLen  = 4
) (
   input  logic                i_clock,
   input  logic                i_rst,
   input  logic [DataBits-1:0] i_tx_data,
   input  logic                i_tx_valid,
   output logic                o_tx_ready,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_ack_ok,
   output logic                o_err,
   input  logic                i_ps2_clk,
   input  logic                i_ps2_dat,
   output logic                o_ps2_clk_oe,
   output logic                o_ps2_dat_oe
);

   localparam int unsigned InhW = $clog2(InhibitCyc + 1);
   localparam int unsigned TmoW = $clog2(TimeoutCyc + 1);
   localparam logic [InhW-1:0] InhLast = InhW'(InhibitCyc - 1);
   localparam logic [TmoW-1:0] TmoMax  = TmoW'(TimeoutCyc);
   localparam logic [KW-1:0]   KLast   = KW'(FrameEdges - 1);
   localparam logic [KW-1:0]   KData   = KW'(DataBits);
   localparam logic [KW-1:0]   KParity = KW'(DataBits + 1);

   ps2_state_e          r_state;
   ps2_state_e          w_state_d;
   logic [DataBits-1:0] r_data;
   logic                r_parity;
   logic [InhW-1:0]     r_cyc;
   logic [KW-1:0]       r_k;
   logic [TmoW-1:0]     r_tmo;
   logic                r_ack;

   logic            w_clk_level;
   logic            w_clk_fall;
   logic            w_dat_level;
   logic            w_dat_fall_unused;
   logic            w_timeout;
   logic            w_shift_bit;
   logic [IdxW-1:0] w_idx;

   ps2_line_filter #(
      .FilterLen(FilterLen)
   ) u_clk_filter (
      .i_clock(i_clock),
      .i_rst  (i_rst),
      .i_pin  (i_ps2_clk),
      .o_level(w_clk_level),
      .o_fall (w_clk_fall)
   );

   ps2_line_filter #(
      .FilterLen(FilterLen)
   ) u_dat_filter (
      .i_clock(i_clock),
      .i_rst  (i_rst),
      .i_pin  (i_ps2_dat),
      .o_level(w_dat_level),
      .o_fall (w_dat_fall_unused)
   );

   assign w_timeout = (r_tmo == TmoMax);
   assign w_idx     = IdxW'(r_k - KW'(1));

   always_ff @(posedge i_clock or posedge i_rst) begin
      if (i_rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle:    if (i_tx_valid) w_state_d = StInhibit;
         StInhibit: if (r_cyc == InhLast) w_state_d = StRts;
         StRts:     w_state_d = StShift;
         StShift: begin
            if (w_timeout) begin
               w_state_d = StIdle;
            end else if (w_clk_fall && (r_k == KLast)) begin
               w_state_d = StRelease;
            end
         end
         StRelease: begin
            if (w_timeout) begin
               w_state_d = StIdle;
            end else if (w_clk_level && w_dat_level) begin
               w_state_d = StDone;
            end
         end
         StDone:    w_state_d = StIdle;
         default:   w_state_d = StIdle;
      endcase
   end

   // Frame datapath: latched byte/parity, inhibit timer, edge counter, edge timeout.
   always_ff @(posedge i_clock or posedge i_rst) begin
      if (i_rst) begin
         r_data   <= '0;
         r_parity <= 1'b0;
         r_cyc    <= '0;
         r_k      <= '0;
         r_tmo    <= '0;
         r_ack    <= 1'b0;
      end else begin
         case (r_state)
            StIdle: begin
               if (i_tx_valid) begin
                  r_data   <= i_tx_data;
                  r_parity <= odd_parity(i_tx_data);
                  r_cyc    <= '0;
                  r_k      <= '0;
                  r_tmo    <= '0;
                  r_ack    <= 1'b0;
               end
            end
            StInhibit: r_cyc <= r_cyc + 1'b1;
            StRts: begin
               r_k   <= '0;
               r_tmo <= '0;
            end
            StShift: begin
               if (w_clk_fall) begin
                  r_k   <= r_k + 1'b1;
                  r_tmo <= '0;
                  if (r_k == KLast) r_ack <= ~w_dat_level;
               end else if (!w_timeout) begin
                  r_tmo <= r_tmo + 1'b1;
               end
            end
            StRelease: if (!w_timeout) r_tmo <= r_tmo + 1'b1;
            default: ;
         endcase
      end
   end

   // k=0 start bit, 1..8 data LSB first, 9 parity, 10 stop (released).
   always_comb begin
      w_shift_bit = 1'b0;
      if (r_k == '0) begin
         w_shift_bit = 1'b1;
      end else if (r_k <= KData) begin
         w_shift_bit = ~r_data[w_idx];
      end else if (r_k == KParity) begin
         w_shift_bit = ~r_parity;
      end
   end

   always_comb begin
      o_tx_ready   = (r_state == StIdle);
      o_busy       = (r_state != StIdle);
      o_done       = 1'b0;
      o_ack_ok     = 1'b0;
      o_err        = 1'b0;
      o_ps2_clk_oe = 1'b0;
      o_ps2_dat_oe = 1'b0;
      unique case (r_state)
         StIdle:    ;
         StInhibit: o_ps2_clk_oe = 1'b1;
         StRts:     o_ps2_dat_oe = 1'b1;
         StShift: begin
            o_err        = w_timeout;
            o_ps2_dat_oe = w_shift_bit & ~w_timeout;
         end
         StRelease: o_err = w_timeout;
         StDone: begin
            o_done   = 1'b1;
            o_ack_ok = r_ack;
         end
         default: ;
      endcase
   end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: sends one command byte (LED set, reset 0xFF, typematic 0xF3, ...) to a keyboard or mouse on the PS2_CLK/PS2_DAT open-drain pair.
- Counterpart to the PS/2 receiver path; sits beside it on the same pins at board top level.
- Implements inhibit, request-to-send, device-clocked bit shifting, odd parity, stop bit and ACK check, with timeout recovery.

Parameters:
- INHIBIT_CYC, 3000, cycles the host holds PS2 clock low before request-to-send (120 us at 25 MHz).
- TIMEOUT_CYC, 50000, maximum cycles between device clock edges, and for final bus release, before abort (2 ms at 25 MHz).
- FILTER_LEN, 4, consecutive identical synchronized samples required to accept a level change on either PS/2 line.

Ports:
- clock  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- tx_data  in  8  byte to send
- tx_valid  in  1  request; accepted when tx_valid && tx_ready
- tx_ready  out  1  high only in IDLE
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when a transfer completes
- ack_ok  out  1  valid with done: 1 = device ACK seen (data low on 11th clock)
- err  out  1  one-cycle pulse on timeout abort
- ps2_clk_i  in  1  raw PS/2 clock pin level
- ps2_dat_i  in  1  raw PS/2 data pin level
- ps2_clk_oe  out  1  1 = drive clock pin low, 0 = release (top level: assign PS2_CLK = oe ? 0 : z)
- ps2_dat_oe  out  1  1 = drive data pin low, 0 = release

Behaviour:
- Reset values: tx_ready=1, busy=0, done=0, ack_ok=0, err=0, both oe=0, state=IDLE, all counters 0.
- Input conditioning: 2-flop synchronizer, then glitch filter (FILTER_LEN matching samples). Falling edge = filtered clock goes 1→0.
- Handshake: tx_data is latched on accept. Parity latched as ~^tx_data (odd parity). tx_valid is ignored while busy.
- State IDLE: both oe=0. On accept → INHIBIT; cycle counter cleared.
- State INHIBIT: clk_oe=1 for exactly INHIBIT_CYC cycles. Then → RTS.
- State RTS: dat_oe=1 (start bit 0), clk_oe=0 released in the same cycle. Edge counter k=0, timeout counter cleared. → SHIFT.
- State SHIFT: on each falling edge, k increments and the timeout counter clears.
  - k=1..8: dat_oe = ~data[k-1] (LSB first).
  - k=9: dat_oe = ~parity.
  - k=10: dat_oe=0 (stop bit, released).
  - k=11: sample filtered data; ack_ok_reg = ~data; → RELEASE.
- State RELEASE: wait until both filtered lines are 1 → DONE.
- State DONE: one cycle; done=1, ack_ok=ack_ok_reg. → IDLE.
- Timeout: in SHIFT or RELEASE, timeout counter reaching TIMEOUT_CYC → both oe=0, err=1 for one cycle, ack_ok=0, done stays 0, → IDLE.
- done and err are never asserted together.
- Rising edges and stray falling edges in INHIBIT/RTS are ignored.
- Timeout counter width: clog2(TIMEOUT_CYC+1). It saturates and never wraps.
- A NACK (data high at k=11) is not an error: done=1, ack_ok=0. Retry policy belongs to the caller.
- rst mid-transfer: lines released immediately (asynchronous), no done/err pulse.
- Pin levels seen during IDLE are ignored, so received traffic causes no action.

Decomposition:
- Package ps2_pkg: state enum (IDLE, INHIBIT, RTS, SHIFT, RELEASE, DONE) and constants for the PS/2 frame (DATA_BITS=8, FRAME_EDGES=11).
- Sub-module ps2_line_filter (synchronizer + glitch filter + falling-edge strobe), instantiated twice: clock and data. The future receiver reuses it.

Test Plan:
- Send 0xED with a device model clocking at 12.5 kHz and ACKing → clk_oe held low 3000 cycles; data bits 1,0,1,1,0,1,1,1 (LSB first), parity 1, stop released; done=1, ack_ok=1, err=0.
- Send 0x00 → parity bit 1 (dat_oe=0 at k=9); send 0x01 → parity bit 0 (dat_oe=1 at k=9).
- Device leaves data high at the 11th clock → done=1, ack_ok=0, tx_ready=1 on the next cycle.
- Device stops clocking after 5 edges → err pulses TIMEOUT_CYC cycles after the 5th edge; both oe=0; done never asserted.
- 2-cycle glitch on ps2_clk_i during SHIFT → no k increment; frame completes normally.
- rst asserted at k=6 → both oe=0 in the same cycle; after release tx_ready=1, then a new 0xFF transfer completes with ack_ok=1.
